instr_fetch_unit: RTL and testbench

Instruction fetch unit that consumes the 27-bit word address held by the core's program counter, issues single-word read requests to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue for decode. It is the PC's counterpart on the fetch side: it reads the current PC and drives the PC's increment strobe back, once per accepted instruction. It also discards in-flight or buffered fetches on a control-flow redirect.

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues single-word reads at the PC, buffers returned
// instructions in a 2-entry queue, and flushes everything on redirect.
module instr_fetch_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [26:0] pc_addr,
   output logic        pc_inc,
   input  logic        redirect,
   output logic        imem_req,
   output logic [26:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [26:0] instr_pc,
   input  logic        instr_ready
);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [26:0] addr_q, addr_d;
   logic [1:0]  count_q, count_d;
   logic        wptr_q, wptr_d;
   logic        rptr_q, rptr_d;
   logic [31:0] data_q [2];
   logic [31:0] data_d [2];
   logic [26:0] pcs_q [2];
   logic [26:0] pcs_d [2];
   logic        push;
   logic        pop;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      pc_inc  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // pc_addr is stale during a redirect, so wait one cycle
            if (count_q < 2'd2 && !redirect) begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_addr;
            end
         end
         REQ: begin
            if (imem_ack) begin
               pc_inc  = !redirect;
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign push = pc_inc;
   assign pop  = instr_ready && (count_q != 2'd0);

   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      data_d  = data_q;
      pcs_d   = pcs_q;
      if (push) begin
         data_d[wptr_q] = imem_rdata;
         pcs_d[wptr_q]  = addr_q;
         wptr_d         = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
      // A redirect wins over any same-cycle push or pop
      if (redirect) begin
         count_d = 2'd0;
         wptr_d  = 1'b0;
         rptr_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         count_q   <= '0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         pcs_q[0]  <= '0;
         pcs_q[1]  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         data_q  <= data_d;
         pcs_q   <= pcs_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr_valid = (count_q != 2'd0);
   assign instr_data  = data_q[rptr_q];
   assign instr_pc    = pcs_q[rptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small PC model and a memory
// that returns {5'b10100, address} as the instruction word.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [26:0] pc_addr;
   logic        pc_inc;
   logic        redirect;
   logic        imem_req;
   logic [26:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [26:0] instr_pc;
   logic        instr_ready;

   logic        auto_ack;
   logic        ack_man;
   logic        pc_ld;
   logic [26:0] pc_ld_val;

   int passed = 0;
   int total  = 0;

   instr_fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .pc_addr     (pc_addr),
      .pc_inc      (pc_inc),
      .redirect    (redirect),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   always #5 clock = ~clock;

   assign imem_ack   = auto_ack ? imem_req : ack_man;
   assign imem_rdata = {5'b10100, imem_addr};

   always @(posedge clock) begin
      if (pc_ld)       pc_addr <= pc_ld_val;
      else if (pc_inc) pc_addr <= pc_addr + 27'd1;
   end

   function automatic logic [31:0] word(input logic [26:0] a);
      return {5'b10100, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input logic [26:0] pcv);
      reset     = 1'b1;
      pc_ld     = 1'b1;
      pc_ld_val = pcv;
      step();
      step();
      reset = 1'b0;
      pc_ld = 1'b0;
   endtask

   initial begin
      pc_addr     = '0;
      redirect    = 1'b0;
      instr_ready = 1'b1;
      auto_ack    = 1'b1;
      ack_man     = 1'b0;
      pc_ld       = 1'b0;
      pc_ld_val   = '0;
      reset       = 1'b1;
      #1;
      do_reset(27'd0);
      reset = 1'b1;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_data", instr_data, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_inc", pc_inc, 0);
      reset = 1'b0;

      // zero-wait streaming from PC 0
      for (int k = 0; k < 4; k++) begin
         step();
         chk("s1_req", imem_req, 1);
         chk("s1_addr", imem_addr, k);
         chk("s1_inc", pc_inc, 1);
         step();
         chk("s1_valid", instr_valid, 1);
         chk("s1_ipc", instr_pc, k);
         chk("s1_data", instr_data, word(27'(k)));
         chk("s1_reqlo", imem_req, 0);
         chk("s1_inclo", pc_inc, 0);
      end

      // queue fills with decode stalled
      instr_ready = 1'b0;
      do_reset(27'd0);
      step();
      chk("s2_a0", imem_addr, 0);
      step();
      step();
      chk("s2_a1", imem_addr, 1);
      chk("s2_req1", imem_req, 1);
      step();
      chk("s2_full_head", instr_pc, 0);
      step();
      chk("s2_full_req", imem_req, 0);
      step();
      chk("s2_full_req2", imem_req, 0);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("s2_pop_head", instr_pc, 1);
      chk("s2_pop_req", imem_req, 0);
      step();
      chk("s2_req2", imem_req, 1);
      chk("s2_a2", imem_addr, 2);

      // redirect while a slow request is pending
      auto_ack    = 1'b0;
      instr_ready = 1'b1;
      do_reset(27'h20);
      step();
      chk("s3_req", imem_req, 1);
      chk("s3_addr", imem_addr, 27'h20);
      redirect  = 1'b1;
      pc_ld     = 1'b1;
      pc_ld_val = 27'h100;
      #1;
      chk("s3_inc_redir", pc_inc, 0);
      step();
      redirect = 1'b0;
      pc_ld    = 1'b0;
      chk("s3_drop_req", imem_req, 1);
      chk("s3_drop_addr", imem_addr, 27'h20);
      step();
      chk("s3_drop_req2", imem_req, 1);
      ack_man = 1'b1;
      #1;
      chk("s3_drop_inc", pc_inc, 0);
      step();
      ack_man = 1'b0;
      chk("s3_idle_req", imem_req, 0);
      chk("s3_empty", instr_valid, 0);
      step();
      chk("s3_new_req", imem_req, 1);
      chk("s3_new_addr", imem_addr, 27'h100);
      ack_man = 1'b1;
      #1;
      chk("s3_new_inc", pc_inc, 1);
      step();
      ack_man     = 1'b0;
      instr_ready = 1'b0;
      chk("s3_valid", instr_valid, 1);
      chk("s3_ipc", instr_pc, 27'h100);

      // redirect coinciding with ack, one entry queued
      step();
      chk("s4_addr", imem_addr, 27'h101);
      ack_man   = 1'b1;
      redirect  = 1'b1;
      pc_ld     = 1'b1;
      pc_ld_val = 27'h200;
      #1;
      chk("s4_inc", pc_inc, 0);
      step();
      ack_man  = 1'b0;
      redirect = 1'b0;
      pc_ld    = 1'b0;
      chk("s4_flush_valid", instr_valid, 0);
      chk("s4_req", imem_req, 0);

      // push and pop in the same cycle at count 1
      step();
      chk("s5_addr0", imem_addr, 27'h200);
      ack_man = 1'b1;
      step();
      ack_man = 1'b0;
      chk("s5_ipc0", instr_pc, 27'h200);
      step();
      chk("s5_addr1", imem_addr, 27'h201);
      chk("s5_head_old", instr_pc, 27'h200);
      instr_ready = 1'b1;
      ack_man     = 1'b1;
      step();
      instr_ready = 1'b0;
      ack_man     = 1'b0;
      chk("s5_valid", instr_valid, 1);
      chk("s5_head_new", instr_pc, 27'h201);
      chk("s5_data_new", instr_data, word(27'h201));

      // asynchronous reset with a request outstanding
      step();
      chk("s6_req", imem_req, 1);
      chk("s6_addr", imem_addr, 27'h202);
      #2;
      reset = 1'b1;
      #1;
      chk("s6_rst_req", imem_req, 0);
      chk("s6_rst_valid", instr_valid, 0);
      chk("s6_rst_ipc", instr_pc, 0);
      step();
      reset = 1'b0;
      step();
      chk("s6_restart_req", imem_req, 1);
      chk("s6_restart_addr", imem_addr, 27'h202);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
